// File: rtl/ibex_fetch_align_fifo.sv
// ibex_fetch_align_fifo: fetch word FIFO that realigns 16/32-bit instructions; define IBEX_FETCH_FIFO_ERR_EN to track bus errors
module ibex_fetch_align_fifo #(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] redirect_addr_i,
  output logic        busy_o,
  input  logic        in_valid_i,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o
);
`ifdef IBEX_FETCH_FIFO_ERR_EN
  localparam int unsigned W = 33;
`else
  localparam int unsigned W = 32;
`endif
  logic [DEPTH-1:0] valid_q, valid_d, valid_s;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [W-1:0]     mem_s [DEPTH];
  logic [31:1]      addr_q, addr_d;
  logic             busy_q;
  logic [W-1:0]     in_word;
  logic [15:0]      entry1_lo;
  logic             unaligned, compressed, err_ok, fire, pop, placed;
  logic             unused_ra;
  assign unused_ra   = redirect_addr_i[0];
  assign unaligned   = addr_q[1];
  assign entry1_lo   = valid_q[1] ? mem_q[1][15:0] : 16'h0;
  assign out_rdata_o = unaligned ? {entry1_lo, mem_q[0][31:16]} : mem_q[0][31:0];
  assign compressed  = out_rdata_o[1:0] != 2'b11;
  assign out_valid_o = valid_q[0] & (~unaligned | compressed | valid_q[1] | err_ok);
  assign out_addr_o  = {addr_q, 1'b0};
  assign busy_o      = busy_q;
  assign fire        = out_valid_o & out_ready_i;
  // An aligned compressed instruction leaves its upper half in entry 0, so only that case keeps the word.
  assign pop         = fire & (unaligned | ~compressed);
`ifdef IBEX_FETCH_FIFO_ERR_EN
  assign in_word   = {in_err_i, in_rdata_i};
  assign err_ok    = mem_q[0][32];
  assign out_err_o = mem_q[0][32] | (unaligned & ~compressed & valid_q[1] & mem_q[1][32]);
`else
  logic unused_err;
  assign unused_err = in_err_i;
  assign in_word    = in_rdata_i;
  assign err_ok     = 1'b0;
  assign out_err_o  = 1'b0;
`endif
  // Shift on pop, then place the incoming word in the lowest free slot; clear overrides both.
  always_comb begin
    valid_s = pop ? valid_q >> 1 : valid_q;
    for (int i = 0; i < DEPTH - 1; i++) mem_s[i] = pop ? mem_q[i+1] : mem_q[i];
    mem_s[DEPTH-1] = mem_q[DEPTH-1];
    valid_d = valid_s;
    mem_d = mem_s;
    placed = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (in_valid_i && !valid_s[i] && !placed) begin
        valid_d[i] = 1'b1;
        mem_d[i] = in_word;
        placed = 1'b1;
      end
    end
    addr_d = fire ? addr_q + (compressed ? 31'd1 : 31'd2) : addr_q;
    if (clear_i) begin
      valid_d = '0;
      addr_d = redirect_addr_i[31:1];
    end
  end
  // State registers; entries reset to zero so idle outputs read as zero. Entries are contiguous, so
  // occupancy >= DEPTH-1 is just the valid bit of slot DEPTH-2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      addr_q <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      mem_q <= mem_d;
      addr_q <= addr_d;
      busy_q <= valid_d[DEPTH-2];
    end
  end
`ifndef SYNTHESIS
  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(in_valid_i && !clear_i && valid_q[DEPTH-1] && !pop));
`endif
endmodule

// File: tb/tb_ibex_fetch_align_fifo.sv
// tb_ibex_fetch_align_fifo: scoreboard bench with a halfword-stream reference model
module tb_ibex_fetch_align_fifo;
  localparam int unsigned DEPTH = 3;
`ifdef IBEX_FETCH_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        busy_o;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_rdata_i = '0;
  logic        in_err_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;

  ibex_fetch_align_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .redirect_addr_i(redirect_addr_i),
    .busy_o(busy_o), .in_valid_i(in_valid_i), .in_rdata_i(in_rdata_i), .in_err_i(in_err_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_rdata_o(out_rdata_o),
    .out_addr_o(out_addr_o), .out_err_o(out_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the fetched byte stream as a queue of halfwords, cut into instructions.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    bit          c;
  } ins_t;
  ins_t        exq[$];
  logic [15:0] hq[$];
  logic [31:0] ipc;
  bit          skip_lo;

  function automatic void m_clear(input logic [31:0] a);
    hq.delete();
    exq.delete();
    ipc = {a[31:1], 1'b0};
    skip_lo = a[1];
  endfunction

  function automatic void m_push(input logic [31:0] w);
    ins_t t;
    bit go;
    if (!skip_lo) hq.push_back(w[15:0]);
    hq.push_back(w[31:16]);
    skip_lo = 1'b0;
    go = 1'b1;
    while (go && hq.size() > 0) begin
      if (hq[0][1:0] != 2'b11) begin
        t.a = ipc; t.d = {16'h0, hq[0]}; t.c = 1'b1;
        exq.push_back(t);
        ipc = ipc + 32'd2;
        void'(hq.pop_front());
      end else if (hq.size() >= 2) begin
        t.a = ipc; t.d = {hq[1], hq[0]}; t.c = 1'b0;
        exq.push_back(t);
        ipc = ipc + 32'd4;
        void'(hq.pop_front());
        void'(hq.pop_front());
      end else go = 1'b0;
    end
  endfunction

  task automatic step(input bit clr, input logic [31:0] ra, input bit iv, input logic [31:0] d,
                      input bit er, input bit rdy);
    clear_i = clr; redirect_addr_i = ra; in_valid_i = iv; in_rdata_i = d; in_err_i = er;
    out_ready_i = rdy;
    if (clr) m_clear(ra);
    else if (iv) m_push(d);
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  task automatic push(input logic [31:0] d, input bit rdy);
    step(1'b0, 32'h0, 1'b1, d, 1'b0, rdy);
  endtask

  task automatic redirect(input logic [31:0] a);
    step(1'b1, a, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Monitor: pops the scoreboard on each accepted instruction and checks stalled outputs hold.
  bit          hold = 1'b0;
  bit          h_c;
  logic [31:0] h_addr, h_data;
  always @(negedge clk_i) begin
    ins_t e;
    if (!rst_ni || clear_i) hold = 1'b0;
    else begin
      if (hold) begin
        chk("hold_valid", {31'h0, out_valid_o}, 32'h1);
        chk("hold_addr", out_addr_o, h_addr);
        chk("hold_data", h_c ? {16'h0, out_rdata_o[15:0]} : out_rdata_o, h_data);
      end
      if (out_valid_o && out_ready_i) begin
        if (exq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected: instruction %h at %h, none expected", out_rdata_o, out_addr_o);
        end else begin
          e = exq.pop_front();
          chk("sb_addr", out_addr_o, e.a);
          chk("sb_data", e.c ? {16'h0, out_rdata_o[15:0]} : out_rdata_o, e.d);
          chk("sb_err", {31'h0, out_err_o}, 32'h0);
        end
      end
      hold = out_valid_o && !out_ready_i;
      h_c = out_rdata_o[1:0] != 2'b11;
      h_addr = out_addr_o;
      h_data = h_c ? {16'h0, out_rdata_o[15:0]} : out_rdata_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, d;
    m_clear(32'h0);
    #1;
    chk("rst_valid", {31'h0, out_valid_o}, 32'h0);
    chk("rst_addr", out_addr_o, 32'h0);
    chk("rst_rdata", out_rdata_o, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_err", {31'h0, out_err_o}, 32'h0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    // aligned uncompressed
    redirect(32'h80);
    chk("clr_valid", {31'h0, out_valid_o}, 32'h0);
    chk("clr_addr", out_addr_o, 32'h80);
    push(32'h00000013, 1'b0);
    chk("t1_valid", {31'h0, out_valid_o}, 32'h1);
    chk("t1_addr", out_addr_o, 32'h80);
    chk("t1_rdata", out_rdata_o, 32'h00000013);
    idle(1'b1);
    chk("t1_next_addr", out_addr_o, 32'h84);
    chk("t1_empty", {31'h0, out_valid_o}, 32'h0);
    // two compressed in one word
    redirect(32'h80);
    push(32'h00010001, 1'b0);
    chk("t2_addr0", out_addr_o, 32'h80);
    chk("t2_rdata0", {16'h0, out_rdata_o[15:0]}, 32'h1);
    idle(1'b1);
    chk("t2_valid1", {31'h0, out_valid_o}, 32'h1);
    chk("t2_addr1", out_addr_o, 32'h82);
    chk("t2_rdata1", {16'h0, out_rdata_o[15:0]}, 32'h1);
    idle(1'b1);
    chk("t2_empty", {31'h0, out_valid_o}, 32'h0);
    chk("t2_addr2", out_addr_o, 32'h84);
    // unaligned uncompressed spanning two words
    redirect(32'h82);
    push(32'h00130001, 1'b0);
    chk("t3_wait", {31'h0, out_valid_o}, 32'h0);
    push(32'hABCD0000, 1'b0);
    chk("t3_valid", {31'h0, out_valid_o}, 32'h1);
    chk("t3_addr", out_addr_o, 32'h82);
    chk("t3_rdata", out_rdata_o, 32'h00000013);
    idle(1'b1);
    chk("t3_c_valid", {31'h0, out_valid_o}, 32'h1);
    chk("t3_c_addr", out_addr_o, 32'h86);
    chk("t3_c_rdata", {16'h0, out_rdata_o[15:0]}, 32'h0000ABCD);
    idle(1'b1);
    chk("t3_empty", {31'h0, out_valid_o}, 32'h0);
    chk("t3_addr2", out_addr_o, 32'h88);
    // fill to DEPTH while stalled
    redirect(32'h100);
    chk("t4_busy0", {31'h0, busy_o}, 32'h0);
    for (int k = 1; k <= DEPTH; k++) begin
      push(32'h00000013, 1'b0);
      chk("t4_busy", {31'h0, busy_o}, (k >= DEPTH - 1) ? 32'h1 : 32'h0);
      chk("t4_valid", {31'h0, out_valid_o}, 32'h1);
      chk("t4_addr", out_addr_o, 32'h100);
      chk("t4_rdata", out_rdata_o, 32'h00000013);
    end
    idle(1'b0);
    chk("t4_busy_hold", {31'h0, busy_o}, 32'h1);
    // clear beats push and pop
    step(1'b1, 32'h200, 1'b1, 32'h00000013, 1'b0, 1'b1);
    chk("t5_valid", {31'h0, out_valid_o}, 32'h0);
    chk("t5_addr", out_addr_o, 32'h200);
    chk("t5_busy", {31'h0, busy_o}, 32'h0);
    idle(1'b1);
    chk("t5_absent", {31'h0, out_valid_o}, 32'h0);
    // error flag
    redirect(32'h300);
    step(1'b0, 32'h0, 1'b1, 32'h00000013, 1'b1, 1'b0);
    chk("t6_valid", {31'h0, out_valid_o}, 32'h1);
    chk("t6_err", {31'h0, out_err_o}, {31'h0, ERR});
    // asynchronous reset mid-operation
    push(32'h00000013, 1'b0);
    #2 rst_ni = 1'b0;
    m_clear(32'h0);
    #1;
    chk("arst_valid", {31'h0, out_valid_o}, 32'h0);
    chk("arst_addr", out_addr_o, 32'h0);
    chk("arst_busy", {31'h0, busy_o}, 32'h0);
    chk("arst_rdata", out_rdata_o, 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      ra = ($urandom % 8 == 0) ? (32'hFFFFFFF0 | ($urandom % 16)) : $urandom;
      d = $urandom;
      if ($urandom % 2 == 0) d[1:0] = 2'b11;
      if ($urandom % 2 == 0) d[17:16] = 2'b11;
      step($urandom % 50 == 0, ra, !busy_o && ($urandom % 4 != 0), d, 1'b0, $urandom % 3 != 0);
    end
    for (int n = 0; n < 64 && exq.size() > 0; n++) idle(1'b1);
    chk("drain", exq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ibex_fetch_align_fifo.md
# ibex_fetch_align_fifo

Instruction fetch FIFO between the instruction-memory interface and the static branch predictor / ID stage. It buffers 32-bit fetch words, realigns compressed (16-bit) and uncompressed (32-bit) instructions across word boundaries, and presents one instruction per cycle with its PC (`out_rdata_o`, `out_addr_o`, `out_valid_o`). These feed the predictor's `fetch_rdata_i`, `fetch_pc_i` and `fetch_valid_i`. On a redirect from a taken branch, a jump or a prediction, the FIFO is flushed and restarts at the new PC.

## Interface

Parameters:
- `DEPTH`, default 3: number of 32-bit word entries; legal range is 2 to 8.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `clear_i`, in, 1: flush all entries and load the PC from `redirect_addr_i`.
- `redirect_addr_i`, in, 32: new fetch PC. Bit 0 is ignored.
- `busy_o`, out, 1: set when occupancy is DEPTH-1 or more. Upstream must not issue new requests while it is set.
- `in_valid_i`, in, 1: a fetched word arrives this cycle.
- `in_rdata_i`, in, 32: the fetched word.
- `in_err_i`, in, 1: bus error for the arriving word. Used only when `IBEX_FETCH_FIFO_ERR_EN` is defined.
- `out_valid_o`, out, 1: a complete instruction is available.
- `out_ready_i`, in, 1: the consumer accepts the instruction.
- `out_rdata_o`, out, 32: the instruction. A compressed instruction is in bits [15:0].
- `out_addr_o`, out, 32: the PC of `out_rdata_o`.
- `out_err_o`, out, 1: the fetch error for this instruction.

## Operation

- Storage:
  - DEPTH entries. Each entry holds a valid bit and 32 bits of data, plus an err bit when the macro is on.
  - Entries are always contiguous from entry 0. Entry 0 is the oldest.
- Push: when `in_valid_i` is high, the word is written into the lowest free entry. The free entry is computed after any same-cycle pop.
- Overflow: `in_valid_i` arriving while all DEPTH entries are valid and no pop occurs is a protocol violation. The word is dropped and an assertion fires.
- Alignment, driven by internal PC bit 1 (`addr_q[1]`):
  - `addr_q[1]=0`: `out_rdata_o = entry0`. `out_valid_o = v0`.
  - `addr_q[1]=1`: `out_rdata_o = {entry1[15:0], entry0[31:16]}`, with entry1 read as zero if it is not valid.
  - `addr_q[1]=1`, compressed (`entry0[17:16] != 2'b11`): `out_valid_o = v0`.
  - `addr_q[1]=1`, uncompressed: `out_valid_o = v0 & v1`.
- Compressed test: `out_rdata_o[1:0] != 2'b11`.
- Pop, on `out_valid_o & out_ready_i`:
  - Aligned uncompressed: pop entry 0, `addr_q += 4`.
  - Aligned compressed: no pop, `addr_q += 2`.
  - Unaligned compressed: pop entry 0, `addr_q += 2`.
  - Unaligned uncompressed: pop entry 0, `addr_q += 4`. The upper half of the instruction now sits in the new entry 0.
- Pop behaviour: a pop shifts all entries down by one.
- PC arithmetic: `addr_q` is 31 bits (bits [31:1]) and `out_addr_o = {addr_q, 1'b0}`. Adds wrap modulo 2^32.
- Clear:
  - All valid bits are set to 0 and `addr_q` is set to `redirect_addr_i[31:1]`.
  - Any `in_valid_i` in the same cycle is discarded.
  - Clear has priority over push and pop.
- `busy_o` is registered from the next-state occupancy.

## Timing

- Reset values: `out_valid_o=0`, `out_addr_o=0`, `busy_o=0`, `out_err_o=0`, `out_rdata_o=0`. All entries are invalid.
- Latency: 1 cycle from a push to `out_valid_o`. There is no combinational bypass from `in_*` to `out_*`.
- `out_rdata_o`, `out_addr_o` and `out_valid_o` are combinational from registered state only.
- Throughput: one instruction per cycle while data is available. Push and pop are permitted in the same cycle.
- Handshake: while `out_valid_o=1` and `out_ready_i=0`, the outputs must hold stable until the instruction is accepted or `clear_i` is asserted.
- After `clear_i` in cycle N, `out_valid_o=0` in cycle N+1.
- Unaligned uncompressed instruction with only entry 0 valid: `out_valid_o=0` until entry 1 is filled. It becomes 1 in the cycle after that push.
- A reset asserted mid-operation returns the block to the reset values immediately, since reset is asynchronous.

## Configuration

- Macro: `IBEX_FETCH_FIFO_ERR_EN`.
- When defined:
  - Each entry stores `in_err_i`.
  - `out_err_o = err0` for compressed or aligned instructions.
  - For an unaligned uncompressed instruction, `out_err_o = err0 | (v1 & err1)`.
  - An instruction with an error is always valid once `v0` is set, so the error can be reported without waiting for entry 1.
- When undefined: `in_err_i` is ignored, no err storage is built, and `out_err_o` is tied to 0.

## Test plan

- Reset, then `clear_i` with `redirect_addr_i=0x80`, then push 0x00000013 -> next cycle `out_valid_o=1`, `out_addr_o=0x80`, `out_rdata_o=0x00000013`. Accepting it pops entry 0 and `out_addr_o` becomes 0x84.
- Push 0x00010001 (two c.nop instructions) -> instructions appear at 0x80 and 0x82, each with `out_rdata_o[15:0]=0x0001`. Entry 0 pops only after the second.
- Clear to 0x82, push 0x00130001, then push 0xXXXX0000 one cycle later -> the first instruction 0x0013 is at 0x82 as uncompressed. `out_valid_o` stays 0 until the second push, then `out_rdata_o=0x00000013`.
- Fill to DEPTH with `out_ready_i=0` -> `busy_o=1` once occupancy reaches DEPTH-1, and the outputs remain stable.
- Assert `clear_i` together with `in_valid_i` and `out_ready_i` -> the next cycle has `out_valid_o=0` with the PC at the redirect address, and the pushed word is absent.
- With `IBEX_FETCH_FIFO_ERR_EN`, push a word with `in_err_i=1` at an aligned PC -> `out_valid_o=1` and `out_err_o=1`. Without the macro, the same stimulus gives `out_err_o=0`.
